fp_accumulate: RTL and testbench
================================

# fp_accumulate

Multicycle single-precision floating-point accumulator for the IIR datapath. It sums a frame of IEEE-754 float32 terms (filter products), one term per 4 cycles, and presents the frame sum for handoff. The output sits directly upstream of the float-to-int16 converter, so `out_data` is the converter's 32-bit input word. Arithmetic is simplified: truncation, flush-to-zero, saturation, with no NaN or Inf propagation.

## Interface
Parameters:
- none; all widths are fixed at float32.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  a term is present on `in_data`.
- `in_ready`  out  1  the accumulator can accept a term.
- `in_data`  in  32  float32 term (sign[31], exp[30:23], frac[22:0]).
- `in_last`  in  1  the accepted term is the final term of the frame.
- `out_valid`  out  1  `out_data` holds a completed frame sum.
- `out_ready`  in  1  downstream accepts `out_data`.
- `out_data`  out  32  float32 frame sum.

## Operation
- States are IDLE, ALIGN, ADD, NORM and HOLD.
- `in_ready` = (state == IDLE).
- A term is accepted on an edge where `in_valid && in_ready`. The FSM then steps IDLE→ALIGN→ADD→NORM.
- After NORM the FSM goes to IDLE, or to HOLD if the term was flagged `in_last`.
- In HOLD, `out_valid` = 1 and `out_data` = acc. On `out_valid && out_ready` the FSM returns to IDLE and acc is cleared to +0.
- acc is cleared to +0 by reset and after each frame handoff.
- Input conditioning:
  - exp == 0 → the operand is ±0 (denormals are flushed).
  - exp == 255 → the operand is treated as the max finite magnitude with its sign (0x7F7FFFFF / 0xFF7FFFFF).
- ALIGN:
  - Build 27-bit significands {1, frac, 3'b000}.
  - Swap so operand A has the larger magnitude (compare exp, then frac).
  - Shift B right by the exponent difference, discarding bits shifted out. A difference ≥ 27 makes B zero.
- ADD:
  - Equal signs → 28-bit magnitude add.
  - Otherwise → A − B.
  - The result sign is A's sign.
- NORM:
  - Carry out → shift right 1 and increment exp.
  - Otherwise → shift left by the leading-zero count and subtract it from exp.
  - Truncate the 3 low bits (round toward zero).
  - Zero magnitude → +0 (0x00000000), including exact cancellation.
  - Exponent ≤ 0 → +0.
  - Exponent ≥ 255 → max finite magnitude with the result sign.

## Timing
- Reset values: `in_ready` = 1, `out_valid` = 0, `out_data` = 0, state = IDLE.
- Latency and throughput:
  - Term accepted at edge T. ALIGN runs in cycle T+1, ADD in T+2, NORM in T+3.
  - acc is updated at the edge ending NORM.
  - At T+4, `in_ready` = 1 again, or `out_valid` = 1 for a last term.
  - Throughput is one term per 4 cycles; the minimum frame latency is 4 cycles from the last acceptance to `out_valid`.
- `in_ready` is low in ALIGN, ADD, NORM and HOLD. `in_valid` asserted while `in_ready` is low has no effect.
- HOLD:
  - `out_data` and `out_valid` stay stable until `out_ready` is sampled high.
  - Upstream is stalled for the whole time.
  - `in_ready` rises in the cycle after the handoff edge. A new frame's first term is added to +0.
- `rst` high at any edge, including mid-ALIGN/ADD/NORM or in HOLD:
  - Next state IDLE, acc = +0, outputs at their reset values.
  - The in-flight term and any pending sum are discarded.
- A single-term frame (`in_last` on the first term) outputs that term, after conditioning.

## Structure
- Shared package `fp_pkg`:
  - `FP_EXP_BIAS` = 127, `FP_EXP_MAX` = 255.
  - `FP_MAX_POS` = 32'h7F7FFFFF, `FP_ZERO` = 32'h0.
  - State encoding constants (IDLE, ALIGN, ADD, NORM, HOLD).
  - Field-slice widths (EXP_W = 8, FRAC_W = 23, SIG_W = 27).
- Sub-module `lzc_28`: combinational 28-bit leading-zero counter with a 5-bit count output, used in NORM.
- All other logic lives in `fp_accumulate`: the FSM, operand registers and acc register.

## Test plan
- Reset: hold `rst` 2 cycles and release. Expect `in_ready` = 1, `out_valid` = 0, `out_data` = 0; repeat `rst` with `in_valid` high and expect no acceptance.
- Single term: 0x3FC00000 (1.5) with `in_last`, `out_ready` = 1. Expect `out_valid` exactly 4 cycles after acceptance with `out_data` = 0x3FC00000.
- Three terms: 1.0 (0x3F800000), 2.0 (0x40000000), 0.5 (0x3F000000, last). Expect `out_data` = 0x40600000 (3.5) and `in_ready` low 3 cycles after each acceptance.
- Cancellation and backpressure: 0x3F800000 + 0xBF800000 (last), with `out_ready` held low 3 cycles. Expect `out_data` = 0x00000000 held stable and `in_ready` = 0 throughout. Then a second frame 0x40400000 (last) gives 0x40400000.
- Saturation and flush: 0x7F7FFFFF + 0x7F7FFFFF (last) gives 0x7F7FFFFF; term 0x00400000 (denormal, last) gives 0x00000000; term 0x7F800000 (Inf, last) gives 0x7F7FFFFF.
- Reset mid-operation: accept 0x40000000, assert `rst` during ADD. Expect no `out_valid`; then frame 0x40000000 (last) gives exactly 0x40000000 (acc was cleared).

Source files
------------

// File: rtl/fp_pkg.sv
// fp_pkg: shared float32 constants, FSM states and operand conditioning helpers
package fp_pkg;
  localparam int EXP_W = 8;
  localparam int FRAC_W = 23;
  localparam int SIG_W = 27;
  localparam int FP_EXP_BIAS = 127;
  localparam int FP_EXP_MAX = 255;
  localparam logic [31:0] FP_MAX_POS = 32'h7F7FFFFF;
  localparam logic [31:0] FP_ZERO = 32'h0;
  typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, HOLD} state_t;
  function automatic logic [31:0] fp_cond(input logic [31:0] f);
    return f[30:23] == 8'hFF ? {f[31], FP_MAX_POS[30:0]} : f[30:23] == 8'h00 ? {f[31], 31'h0} : f;
  endfunction
  function automatic logic [SIG_W-1:0] fp_sig(input logic [31:0] f);
    return f[30:23] == 8'h00 ? '0 : {1'b1, f[FRAC_W-1:0], 3'b000};
  endfunction
endpackage

// File: rtl/lzc_28.sv
// lzc_28: combinational leading-zero counter for the 28-bit sum
module lzc_28 (
  input  logic [27:0] v,
  output logic [4:0]  cnt
);
  always_comb begin
    cnt = 5'd28;
    for (int i = 0; i < 28; i++) if (v[i]) cnt = 5'(27 - i);
  end
endmodule

// File: rtl/fp_accumulate.sv
// fp_accumulate: multicycle float32 frame accumulator (truncate, flush-to-zero, saturate)
module fp_accumulate
  import fp_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic        in_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data
);
  state_t state, state_n;
  logic [31:0] acc, term, res;
  logic last, a_sign, sub, x_big;
  logic [EXP_W-1:0] a_exp, d;
  logic [SIG_W-1:0] a_sig, b_sig, x_sig, y_sig;
  logic [SIG_W:0] sum;
  logic [4:0] lz, sh;
  logic [FRAC_W-1:0] frac;
  logic signed [9:0] e;
  assign in_ready = state == IDLE;
  assign out_valid = state == HOLD;
  assign out_data = acc;
  assign x_sig = fp_sig(term);
  assign y_sig = fp_sig(acc);
  assign x_big = term[30:0] >= acc[30:0];
  assign d = x_big ? term[30:23] - acc[30:23] : acc[30:23] - term[30:23];
  lzc_28 u_lzc (.v(sum), .cnt(lz));
  assign sh = lz - 5'd1;
  assign frac = 23'((sum[SIG_W] ? sum >> 1 : sum << sh) >> 3);
  assign e = sum[SIG_W] ? $signed({2'b00, a_exp}) + 10'sd1
                        : $signed({2'b00, a_exp}) + 10'sd1 - $signed({5'b00000, lz});
  assign res = (sum == '0 || e <= 10'sd0) ? FP_ZERO
             : e >= 10'sd255 ? {a_sign, FP_MAX_POS[30:0]} : {a_sign, e[7:0], frac};
  always_comb begin
    state_n = state == IDLE ? (in_valid ? ALIGN : IDLE)
            : state == ALIGN ? ADD
            : state == ADD ? NORM
            : state == NORM ? (last ? HOLD : IDLE)
            : (out_ready ? IDLE : HOLD);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      acc <= FP_ZERO;
    end else begin
      state <= state_n;
      if (state == NORM) acc <= res;
      else if (state == HOLD && out_ready) acc <= FP_ZERO;
    end
  end
  // the larger-magnitude operand becomes A; B's shifted-out bits are simply lost
  always_ff @(posedge clk) begin
    if (state == IDLE && in_valid) begin
      term <= fp_cond(in_data);
      last <= in_last;
    end
    if (state == ALIGN) begin
      a_sign <= x_big ? term[31] : acc[31];
      a_exp <= x_big ? term[30:23] : acc[30:23];
      a_sig <= x_big ? x_sig : y_sig;
      b_sig <= d >= 8'd27 ? '0 : (x_big ? y_sig : x_sig) >> d;
      sub <= term[31] ^ acc[31];
    end
    if (state == ADD) sum <= sub ? {1'b0, a_sig} - {1'b0, b_sig} : {1'b0, a_sig} + {1'b0, b_sig};
  end
endmodule

// File: tb/tb_fp_accumulate.sv
// tb_fp_accumulate: directed and random frames checked against a value-level float model
module tb_fp_accumulate;
  logic clk = 0, rst = 1, in_valid = 0, in_last = 0, out_ready = 0;
  logic [31:0] in_data = 0;
  logic in_ready, out_valid;
  logic [31:0] out_data;
  int errors = 0, checks = 0;
  logic [31:0] macc = 0;

  fp_accumulate dut (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data));

  always #5 clk = ~clk;

  function automatic logic [31:0] cond(input logic [31:0] f);
    if (f[30:23] == 8'hFF) return {f[31], 31'h7F7FFFFF};
    if (f[30:23] == 8'h00) return {f[31], 31'h0};
    return f;
  endfunction

  // sum as scaled integers: 24-bit mantissa with 3 guard bits, then renormalise
  function automatic logic [31:0] ref_add(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] x, y;
    bit sx, sy;
    int ex, ey, e;
    longint mx, my, s, t;
    x = cond(a); y = cond(b);
    sx = x[31]; sy = y[31]; ex = int'(x[30:23]); ey = int'(y[30:23]);
    mx = ex == 0 ? 0 : longint'({1'b1, x[22:0]}) * 8;
    my = ey == 0 ? 0 : longint'({1'b1, y[22:0]}) * 8;
    if (ey > ex || (ey == ex && my > mx)) begin
      t = mx; mx = my; my = t;
      e = ex; ex = ey; ey = e;
      sx = sy; sy = x[31];
    end
    my = (ex - ey >= 27) ? 0 : my >> (ex - ey);
    s = (sx == sy) ? mx + my : mx - my;
    if (s == 0) return 32'h0;
    e = ex;
    while (s >= (64'd1 << 27)) begin s = s >> 1; e++; end
    while (s < (64'd1 << 26)) begin s = s << 1; e--; end
    if (e <= 0) return 32'h0;
    if (e >= 255) return {sx, 31'h7F7FFFFF};
    return {sx, e[7:0], s[25:3]};
  endfunction

  task automatic step;
    @(posedge clk); #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [31:0] d, input bit l);
    chk("ready_idle", 32'(in_ready), 32'd1);
    in_valid = 1; in_data = d; in_last = l;
    step;
    macc = ref_add(macc, d);
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'($urandom_range(0, 1)); in_data = $urandom; in_last = 1'($urandom_range(0, 1));
      chk("busy_ready", 32'(in_ready), 32'd0);
      chk("busy_valid", 32'(out_valid), 32'd0);
      step;
    end
    in_valid = 0; in_last = 0;
    chk("t4_ready", 32'(in_ready), 32'(!l));
    chk("t4_valid", 32'(out_valid), 32'(l));
  endtask

  task automatic take(input int stall, input logic [31:0] exp);
    for (int i = 0; i < stall; i++) begin
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_data", out_data, exp);
      chk("hold_ready", 32'(in_ready), 32'd0);
      step;
    end
    out_ready = 1;
    chk("out_valid", 32'(out_valid), 32'd1);
    chk("out_data", out_data, exp);
    step;
    out_ready = 0; macc = 0;
    chk("after_valid", 32'(out_valid), 32'd0);
    chk("after_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    step; step; rst = 0;
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", out_data, 32'h0);
    rst = 1; in_valid = 1; in_data = 32'h3F800000;
    step; rst = 0; in_valid = 0;
    chk("rst_noaccept", 32'(in_ready), 32'd1);

    send(32'h3FC00000, 1); take(0, 32'h3FC00000);
    send(32'h3F800000, 0); send(32'h40000000, 0); send(32'h3F000000, 1); take(0, 32'h40600000);
    send(32'h3F800000, 0); send(32'hBF800000, 1); take(3, 32'h00000000);
    send(32'h40400000, 1); take(0, 32'h40400000);
    send(32'h7F7FFFFF, 0); send(32'h7F7FFFFF, 1); take(0, 32'h7F7FFFFF);
    send(32'h00400000, 1); take(0, 32'h00000000);
    send(32'h7F800000, 1); take(0, 32'h7F7FFFFF);

    in_valid = 1; in_data = 32'h40000000; in_last = 0;
    step; in_valid = 0; step;
    rst = 1; step; rst = 0;
    macc = 0;
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_ready", 32'(in_ready), 32'd1);
    chk("midrst_data", out_data, 32'h0);
    step;
    chk("midrst_still", 32'(out_valid), 32'd0);
    send(32'h40000000, 1); take(0, 32'h40000000);

    for (int f = 0; f < 12; f++) begin
      int n;
      n = $urandom_range(1, 4);
      for (int k = 0; k < n; k++) begin
        logic [31:0] t;
        t = {1'($urandom_range(0, 1)), 8'($urandom_range(118, 136)), 23'($urandom)};
        if ($urandom_range(0, 9) == 0) t = {t[31], 8'h00, t[22:0]};
        send(t, k == n - 1);
      end
      take($urandom_range(0, 2), macc);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
